// File: rtl/mdu_pkg.sv
// mdu_pkg: shared multiply/divide unit encodings and divider state type.
package mdu_pkg;
  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring step on {R,Q} against divisor D.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_r,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_d,
  output logic [XLEN-1:0] o_r,
  output logic [XLEN-1:0] o_q
);
  logic [XLEN:0] w_sh, w_diff;
  assign w_sh   = {i_r, i_q[XLEN-1]};
  // R < D on entry keeps the shifted value below 2D, so bit XLEN is a pure borrow.
  assign w_diff = w_sh - {1'b0, i_d};
  assign o_r    = w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_q    = {i_q[XLEN-2:0], ~w_diff[XLEN]};
endmodule

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider for DIV/DIVU/REM/REMU.
// Define DIV_FASTPATH_EN to finish divide-by-zero, overflow and |A|<|B| straight from IDLE.
module div_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic            FlushE,
  input  logic            Ack,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);
  localparam int CW = $clog2(XLEN);
  div_state_t      r_state, w_next;
  logic [XLEN-1:0] r_r, r_q, r_d, r_a, r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_negq, r_negr, r_rem, r_div0, r_ovf;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_r_nxt, w_q_nxt;
  logic            w_signed, w_sa, w_sb, w_div0, w_ovf, w_start, w_last, w_fast;

  // Corner cases are resolved here, never by the iteration itself.
  function automatic logic [XLEN-1:0] fixup(input logic rem, input logic [XLEN-1:0] q, r,
                                            input logic nq, nr, dz, ov, input logic [XLEN-1:0] a);
    logic [XLEN-1:0] fq, fr;
    fq = dz ? '1 : ov ? a  : nq ? -q : q;
    fr = dz ? a  : ov ? '0 : nr ? -r : r;
    return rem ? fr : fq;
  endfunction

  assign w_signed = Funct3E[2] & ~Funct3E[0];
  assign w_sa     = w_signed & ForwardedSrcAE[XLEN-1];
  assign w_sb     = w_signed & ForwardedSrcBE[XLEN-1];
  assign w_abs_a  = w_sa ? -ForwardedSrcAE : ForwardedSrcAE;
  assign w_abs_b  = w_sb ? -ForwardedSrcBE : ForwardedSrcBE;
  assign w_div0   = ForwardedSrcBE == '0;
  assign w_ovf    = w_signed & (ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&ForwardedSrcBE);
  assign w_start  = (r_state == DIV_IDLE) & StartE & ~FlushE;
  assign w_last   = (r_state == DIV_BUSY) & (r_cnt == '0) & ~FlushE;
`ifdef DIV_FASTPATH_EN
  assign w_fast   = w_div0 | w_ovf | (w_abs_a < w_abs_b);
`else
  assign w_fast   = 1'b0;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .i_r(r_r),
    .i_q(r_q),
    .i_d(r_d),
    .o_r(w_r_nxt),
    .o_q(w_q_nxt)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (FlushE) w_next = DIV_IDLE;
    else if (w_start) w_next = w_fast ? DIV_DONE : DIV_BUSY;
    else if (w_last) w_next = DIV_DONE;
    else if ((r_state == DIV_DONE) && Ack) w_next = DIV_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r      <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_rem    <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
    end else if (w_start) begin
      r_r    <= '0;
      r_q    <= w_abs_a;
      r_d    <= w_abs_b;
      r_a    <= ForwardedSrcAE;
      r_cnt  <= CW'(XLEN-1);
      r_negq <= w_sa ^ w_sb;
      r_negr <= w_sa;
      r_rem  <= Funct3E[1];
      r_div0 <= w_div0;
      r_ovf  <= w_ovf;
      if (w_fast)
        r_result <= fixup(Funct3E[1], '0, w_abs_a, w_sa ^ w_sb, w_sa, w_div0, w_ovf, ForwardedSrcAE);
    end else if ((r_state == DIV_BUSY) && !FlushE) begin
      r_r   <= w_r_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - 1'b1;
      if (w_last)
        r_result <= fixup(r_rem, w_q_nxt, w_r_nxt, r_negq, r_negr, r_div0, r_ovf, r_a);
    end
  end

  assign Busy   = r_state == DIV_BUSY;
  assign Done   = r_state == DIV_DONE;
  assign Result = r_result;
endmodule
